sub_serial: RTL

SUB_SERIAL -- requirements
Module: sub_serial

---
 rtl/serial_arith_pkg.sv | 12 +
 rtl/fsub_bit.sv | 17 +
 rtl/sub_serial.sv | 131 +++++++++++++
 3 files changed

// File: rtl/serial_arith_pkg.sv
// rtl/serial_arith_pkg.sv - shared state encoding and defaults for the serial arithmetic blocks
package serial_arith_pkg;

  localparam int WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/fsub_bit.sv
// rtl/fsub_bit.sv - one-bit full subtractor (difference and borrow out)
module fsub_bit (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  // Difference is the parity of the three inputs; a borrow is needed when
  // y plus the incoming borrow exceeds x.
  always_comb begin
    d    = x ^ y ^ bin;
    bout = (~x & y) | (~x & bin) | (y & bin);
  end

endmodule

// File: rtl/sub_serial.sv
// rtl/sub_serial.sv - bit-serial subtractor a-b, LSB first; SUB_SERIAL_OVF_EN adds the ovf port
module sub_serial
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out,
  output logic             borrow,
  output logic             done
`ifdef SUB_SERIAL_OVF_EN
  ,
  output logic             ovf
`endif
);

  // One extra bit so the counter can reach WIDTH without wrapping.
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             borrow_q, borrow_d;
  logic             done_q, done_d;
  logic             bit_diff;
  logic             bit_bout;
`ifdef SUB_SERIAL_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  fsub_bit u_fsub_bit (
    .x    (a_q[0]),
    .y    (b_q[0]),
    .bin  (borrow_q),
    .d    (bit_diff),
    .bout (bit_bout)
  );

  // Next-state logic: load on start, shift one bit per SUB cycle, hold otherwise.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    out_d    = out_q;
    borrow_d = borrow_q;
`ifdef SUB_SERIAL_OVF_EN
    ovf_d    = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (en) begin
          a_d      = a;
          b_d      = b;
          cnt_d    = '0;
          out_d    = '0;
          borrow_d = 1'b0;
`ifdef SUB_SERIAL_OVF_EN
          ovf_d    = 1'b0;
`endif
          state_d  = SUB;
        end
      end
      SUB: begin
        out_d    = {bit_diff, out_q[WIDTH-1:1]};
        a_d      = a_q >> 1;
        b_d      = b_q >> 1;
        borrow_d = bit_bout;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
`ifdef SUB_SERIAL_OVF_EN
          // Signed overflow: borrow into the sign bit differs from borrow out of it.
          ovf_d   = borrow_q ^ bit_bout;
`endif
        end
      end
      DONE: begin
        if (en) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    done_d = (state_d == DONE);
  end

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      out_q    <= '0;
      borrow_q <= 1'b0;
      done_q   <= 1'b0;
`ifdef SUB_SERIAL_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
      borrow_q <= borrow_d;
      done_q   <= done_d;
`ifdef SUB_SERIAL_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign out    = out_q;
  assign borrow = borrow_q;
  assign done   = done_q;
`ifdef SUB_SERIAL_OVF_EN
  assign ovf    = ovf_q;
`endif

endmodule
